// File: rtl/fetch_buffered_pkg.sv
// rtl/fetch_buffered_pkg.sv - shared fetch addresses, NOP encoding and redirect priority
package fetch_buffered_pkg;

   localparam logic [31:0] PC_RESET_ADDR  = 32'h0000_0000;
   localparam logic [31:0] PC_ILLOP_ADDR  = 32'h8000_0000;
   localparam logic [31:0] PC_EXCEPT_ADDR = 32'h8000_0080;
   localparam logic [31:0] INST_NOP       = 32'h0000_0013;

   typedef enum logic [2:0] {
      REDIR_NONE,
      REDIR_ILL,
      REDIR_IRQ,
      REDIR_JMP,
      REDIR_BR
   } redir_e;

   // Illegal op beats interrupt beats jump beats a taken branch.
   function automatic redir_e redir_sel(input logic op_ill, input logic irq,
                                        input logic op_jmp, input logic op_beq,
                                        input logic op_bne, input logic zr);
      if (op_ill) return REDIR_ILL;
      if (irq) return REDIR_IRQ;
      if (op_jmp) return REDIR_JMP;
      if ((op_beq && zr) || (op_bne && !zr)) return REDIR_BR;
      return REDIR_NONE;
   endfunction

endpackage

// File: rtl/fetch_buffered_if.sv
// rtl/fetch_buffered_if.sv - instruction memory request/response bus
interface fetch_buffered_if #(
   parameter int XLEN = 32
);
   logic            i_mem_req;
   logic            i_mem_ready;
   logic [XLEN-1:0] i_mem_addr;
   logic            i_mem_rvalid;
   logic [XLEN-1:0] i_mem_rdata;

   modport master (
      output i_mem_req, i_mem_addr,
      input  i_mem_ready, i_mem_rvalid, i_mem_rdata
   );

   modport slave (
      input  i_mem_req, i_mem_addr,
      output i_mem_ready, i_mem_rvalid, i_mem_rdata
   );
endinterface

// File: rtl/fetch_buffered_fifo.sv
// rtl/fetch_buffered_fifo.sv - prefetch queue with flush; count tracks 0..DEPTH
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic                           pop,
   input  logic                           flush,
   input  logic [WIDTH-1:0]               din,
   output logic [WIDTH-1:0]               dout,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           empty,
   output logic                           full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/fetch_buffered.sv
// rtl/fetch_buffered.sv - prefetching fetch stage: one outstanding request, queue to decode
module fetch_buffered
   import fetch_buffered_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] PC_RESET = XLEN'(PC_RESET_ADDR),
   parameter logic [XLEN-1:0] PC_ILLOP = XLEN'(PC_ILLOP_ADDR),
   parameter logic [XLEN-1:0] PC_XADR  = XLEN'(PC_EXCEPT_ADDR)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              irq,
   input  logic              op_ill,
   input  logic              op_jmp,
   input  logic              op_beq,
   input  logic              op_bne,
   input  logic              zr,
   input  logic [XLEN-1:0]   br_addr,
   input  logic [XLEN-1:0]   j_addr,
   fetch_buffered_if.master  imem,
   output logic [XLEN-1:0]   pc_next,
   output logic [XLEN-1:0]   ir_next,
   output logic              ir_valid
);
   localparam int CW = $clog2(DEPTH+1);

   typedef struct packed {
      logic [XLEN-1:0] pc4;
      logic [XLEN-1:0] instr;
   } entry_t;

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] req_pc;
   logic [XLEN-1:0] pc_hold;
   logic [XLEN-1:0] target;
   logic            outstanding;
   logic            discard;
   redir_e          redir;
   logic            redirect;
   entry_t          head;
   entry_t          push_entry;
   logic [CW-1:0]   count;
   logic            q_empty;
   logic            q_full;
   logic            accept;
   logic            resp;
   logic            push;
   logic            pop;
   logic            unused_full;

   always_comb begin
      redir  = REDIR_NONE;
      target = fetch_pc;
      if (!stall) redir = redir_sel(op_ill, irq, op_jmp, op_beq, op_bne, zr);
      case (redir)
         REDIR_ILL: target = PC_ILLOP;
         REDIR_IRQ: target = PC_XADR;
         REDIR_JMP: target = j_addr;
         REDIR_BR:  target = br_addr;
         default:   ;
      endcase
   end

   assign redirect = (redir != REDIR_NONE);

   // Issue only with nothing in flight, so count alone reserves the response slot.
   assign imem.i_mem_req  = !rst && !outstanding && (count < CW'(DEPTH));
   assign imem.i_mem_addr = fetch_pc;
   assign accept          = imem.i_mem_req && imem.i_mem_ready;
   assign resp            = imem.i_mem_rvalid && outstanding;
   assign push            = resp && !discard && !redirect;
   assign pop             = !stall && !redirect && !q_empty;
   assign unused_full     = q_full;

   always_comb begin
      push_entry.pc4   = req_pc + XLEN'(4);
      push_entry.instr = imem.i_mem_rdata;
   end

   fetch_fifo #(
      .WIDTH (2*XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .din   (push_entry),
      .dout  (head),
      .count (count),
      .empty (q_empty),
      .full  (q_full)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= PC_RESET;
         req_pc      <= '0;
         pc_hold     <= '0;
         outstanding <= 1'b0;
         discard     <= 1'b0;
      end else begin
         if (redirect)    fetch_pc <= target;
         else if (accept) fetch_pc <= fetch_pc + XLEN'(4);
         if (accept) req_pc <= fetch_pc;
         if (accept)    outstanding <= 1'b1;
         else if (resp) outstanding <= 1'b0;
         // A response landing in the redirect cycle retires the old request itself.
         if (redirect)  discard <= accept || (outstanding && !imem.i_mem_rvalid);
         else if (resp) discard <= 1'b0;
         if (!q_empty) pc_hold <= head.pc4;
      end
   end

   assign ir_valid = !q_empty && !redirect;
   assign ir_next  = ir_valid ? head.instr : XLEN'(INST_NOP);
   assign pc_next  = q_empty ? pc_hold : head.pc4;
endmodule

// File: tb/tb_fetch_buffered.sv
// tb/tb_fetch_buffered.sv - randomized bench for fetch_buffered with queue-based reference model
module tb_fetch_buffered;
   import fetch_buffered_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall, irq, op_ill, op_jmp, op_beq, op_bne, zr;
   logic [31:0] br_addr, j_addr;
   logic [31:0] pc_next, ir_next;
   logic        ir_valid;

   always #5 clk = ~clk;

   fetch_buffered_if #(.XLEN(32)) mif ();

   fetch_buffered #(.XLEN(32), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .stall    (stall),
      .irq      (irq),
      .op_ill   (op_ill),
      .op_jmp   (op_jmp),
      .op_beq   (op_beq),
      .op_bne   (op_bne),
      .zr       (zr),
      .br_addr  (br_addr),
      .j_addr   (j_addr),
      .imem     (mif),
      .pc_next  (pc_next),
      .ir_next  (ir_next),
      .ir_valid (ir_valid)
   );

   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] m_pc, m_req_pc, m_hold;
   bit          m_out, m_disc;
   logic [63:0] q[$];

   bit          mem_busy;
   logic [31:0] mem_addr;
   int          mem_cnt;
   bit          ready_en;
   int          lat;
   logic [31:0] acc_q[$];

   bit          s_valid, s_req;
   logic [31:0] s_pc, s_ir;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic clear_ctrl();
      stall = 0; irq = 0; op_ill = 0; op_jmp = 0; op_beq = 0; op_bne = 0; zr = 0;
   endtask

   task automatic model_reset();
      m_pc = PC_RESET_ADDR; m_req_pc = '0; m_hold = '0; m_out = 0; m_disc = 0;
      q.delete();
   endtask

   task automatic mem_drive();
      mif.i_mem_rvalid = 1'b0;
      mif.i_mem_rdata  = $urandom;
      if (mem_busy) begin
         if (mem_cnt == 0) begin
            mif.i_mem_rvalid = 1'b1;
            mif.i_mem_rdata  = instr_of(mem_addr);
         end else begin
            mem_cnt--;
         end
      end
      mif.i_mem_ready = ready_en && !mem_busy;
   endtask

   task automatic mem_track();
      if (mif.i_mem_rvalid) mem_busy = 0;
      if (mif.i_mem_req && mif.i_mem_ready) begin
         mem_busy = 1;
         mem_addr = mif.i_mem_addr;
         mem_cnt  = lat;
         acc_q.push_back(mif.i_mem_addr);
      end
   endtask

   // One clock: drive memory, compare at negedge, advance the model.
   task automatic step();
      bit          redir, e_req, e_valid, acc, resp;
      logic [31:0] tgt;
      mem_drive();
      @(negedge clk);
      redir = !stall && (op_ill || irq || op_jmp || (op_beq && zr) || (op_bne && !zr));
      tgt   = op_ill ? PC_ILLOP_ADDR : irq ? PC_EXCEPT_ADDR : op_jmp ? j_addr : br_addr;
      e_req   = !m_out && (q.size() < DEPTH);
      e_valid = (q.size() > 0) && !redir;
      chk("i_mem_req", mif.i_mem_req, e_req);
      if (e_req) chk("i_mem_addr", mif.i_mem_addr, m_pc);
      chk("ir_valid", ir_valid, e_valid);
      chk("ir_next", ir_next, e_valid ? q[0][31:0] : INST_NOP);
      if (q.size() == 0) chk("pc_next_hold", pc_next, m_hold);
      else if (e_valid)  chk("pc_next", pc_next, q[0][63:32]);
      s_valid = ir_valid; s_req = mif.i_mem_req; s_pc = pc_next; s_ir = ir_next;

      acc  = e_req && mif.i_mem_ready;
      resp = mif.i_mem_rvalid && m_out;
      if (q.size() > 0) m_hold = q[0][63:32];
      if (redir) q.delete();
      else if (q.size() > 0 && !stall) void'(q.pop_front());
      if (resp && !m_disc && !redir) q.push_back({m_req_pc + 32'd4, instr_of(m_req_pc)});
      if (redir)     m_disc = acc || (m_out && !mif.i_mem_rvalid);
      else if (resp) m_disc = 0;
      if (acc)       m_out = 1;
      else if (resp) m_out = 0;
      if (acc) m_req_pc = m_pc;
      if (redir)    m_pc = tgt;
      else if (acc) m_pc = m_pc + 32'd4;
      mem_track();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_pulse();
      mem_drive();
      #2 rst = 1'b1;
      #1;
      chk("rst i_mem_req", mif.i_mem_req, 0);
      chk("rst ir_valid", ir_valid, 0);
      chk("rst ir_next", ir_next, INST_NOP);
      chk("rst pc_next", pc_next, 32'h0);
      model_reset();
      @(negedge clk);
      mem_track();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic next_acc(input string nm, input logic [31:0] exp);
      for (int i = 0; i < 30 && acc_q.size() == 0; i++) step();
      if (acc_q.size() == 0) chk({nm, " timeout"}, 0, 1);
      else chk(nm, acc_q[0], exp);
   endtask

   task automatic wait_idle(input string nm, input bit need_space);
      bit ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         ok = !m_out && !mem_busy && (!need_space || q.size() < DEPTH);
         if (!ok) step();
      end
      chk({nm, " idle reached"}, ok, 1);
   endtask

   initial begin
      automatic int          nv;
      automatic bit          first;
      automatic logic [31:0] p0, a;
      automatic bit          ok;
      automatic int          r;

      clear_ctrl();
      br_addr = '0; j_addr = '0;
      ready_en = 0; lat = 0; mem_busy = 0; mem_cnt = 0; mem_addr = '0;
      mif.i_mem_ready = 0; mif.i_mem_rvalid = 0; mif.i_mem_rdata = '0;
      model_reset();
      #1;
      chk("init i_mem_req", mif.i_mem_req, 0);
      chk("init ir_valid", ir_valid, 0);
      chk("init ir_next", ir_next, INST_NOP);
      chk("init pc_next", pc_next, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;

      // Sequential stream, single-cycle memory.
      ready_en = 1; lat = 0; acc_q.delete(); nv = 0; first = 1;
      for (int i = 0; i < 22; i++) begin
         step();
         if (s_valid) begin
            nv++;
            if (first) begin
               chk("first pc_next", s_pc, 32'h4);
               chk("first ir_next", s_ir, instr_of(32'h0));
               first = 0;
            end
         end
      end
      chk("valid count 22 cycles", nv, 10);
      chk("addr0", acc_q[0], 32'h0);
      chk("addr1", acc_q[1], 32'h4);
      chk("addr2", acc_q[2], 32'h8);

      // Fill under stall, then drain with memory idle.
      stall = 1;
      for (int i = 0; i < 10; i++) step();
      chk("req low when full", s_req, 0);
      stall = 0; ready_en = 0; nv = 0; p0 = '0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (s_valid) begin
            if (nv == 0) p0 = s_pc;
            else chk("drain pc ascending", s_pc, p0 + 32'(4 * nv));
            nv++;
         end
      end
      chk("drained entries", nv, DEPTH);

      // Jump with a request outstanding.
      ready_en = 1; lat = 1; ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         ok = m_out && mem_busy && (mem_cnt > 0);
         if (!ok) step();
      end
      chk("jmp setup reached", ok, 1);
      op_jmp = 1; j_addr = 32'h100;
      step();
      chk("jmp cycle ir_valid", s_valid, 0);
      chk("jmp cycle ir_next", s_ir, INST_NOP);
      op_jmp = 0; acc_q.delete();
      step();
      chk("after jmp ir_valid", s_valid, 0);
      next_acc("jmp target", 32'h100);

      // Untaken beq keeps the stream; taken bne redirects.
      lat = 0;
      wait_idle("beq", 0);
      a = m_pc;
      op_beq = 1; zr = 0; br_addr = 32'h80; acc_q.delete();
      step();
      op_beq = 0;
      for (int i = 0; i < 20 && acc_q.size() < 2; i++) step();
      if (acc_q.size() < 2) chk("beq stream timeout", 0, 1);
      else chk("beq untaken next addr", acc_q[1], a + 32'd4);
      op_bne = 1; zr = 0; br_addr = 32'h40;
      step();
      clear_ctrl(); acc_q.delete();
      next_acc("bne target", 32'h40);

      irq = 1; op_ill = 1;
      step();
      clear_ctrl(); acc_q.delete();
      next_acc("illop beats irq", PC_ILLOP_ADDR);
      irq = 1;
      step();
      clear_ctrl(); acc_q.delete();
      next_acc("irq target", PC_EXCEPT_ADDR);

      wait_idle("stalled jmp", 1);
      a = m_pc;
      stall = 1; op_jmp = 1; j_addr = 32'h200; acc_q.delete();
      step();
      clear_ctrl();
      for (int i = 0; i < 20 && acc_q.size() < 2; i++) step();
      if (acc_q.size() < 2) chk("stalled jmp timeout", 0, 1);
      else chk("stalled jmp ignored", acc_q[1], a + 32'd4);

      // Reset with three entries queued and a request in flight.
      stall = 1; lat = 2; ok = 0;
      for (int i = 0; i < 60 && !ok; i++) begin
         ok = (q.size() == 3) && m_out;
         if (!ok) step();
      end
      chk("reset setup reached", ok, 1);
      rst_pulse();
      stall = 0; lat = 0; acc_q.delete();
      next_acc("post-reset addr", PC_RESET_ADDR);
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         step();
         ok = s_valid;
      end
      if (!ok) chk("post-reset valid timeout", 0, 1);
      else chk("post-reset pc_next", s_pc, PC_RESET_ADDR + 32'd4);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom % 100);
         stall   = ((i / 200) % 3 == 1) ? ($urandom % 10 < 8) : ($urandom % 4 == 0);
         op_ill  = (r < 3);
         irq     = (r >= 3 && r < 7) || ($urandom % 50 == 0);
         op_jmp  = (r >= 7 && r < 11);
         op_beq  = (r >= 11 && r < 16);
         op_bne  = (r >= 16 && r < 21);
         zr      = $urandom % 2;
         j_addr  = ($urandom % 8 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
         br_addr = $urandom & 32'h0000_0FFC;
         ready_en = ($urandom % 10) < 7;
         lat      = int'($urandom % 4);
         if ($urandom % 400 == 0) rst_pulse();
         else step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
